apb_stream_master: RTL and testbench

APB bus initiator that drives the I2S transceiver's register interface from the system side. It streams PCM samples from a valid/ready source into the transmit FIFO register and drains the receive FIFO register into a valid/ready sink. Between transfers it polls the flags register, so neither FIFO is overrun or underrun. It sits between the audio datapath and the transceiver's APB port, in the transceiver's `pclk` domain.

---
 rtl/apb_stream_master_pkg.sv | 36 +++
 rtl/apb_stream_master_if.sv | 28 ++
 rtl/apb_stream_master_xfer.sv | 53 +++++
 rtl/apb_stream_master.sv | 140 ++++++++++++++
 tb/tb_apb_stream_master.sv | 321 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/apb_stream_master_pkg.sv
// Shared types and constants for the APB stream master and the transceiver's
// address decode.
package apb_stream_master_pkg;

    typedef enum logic [3:0] {
        IDLE,
        CFG_S,
        CFG_A,
        POLL_S,
        POLL_A,
        DECIDE,
        WR_S,
        WR_A,
        RD_S,
        RD_A
    } apbm_state_t;

    // Bit positions inside the transceiver flags register
    localparam int unsigned FL_TX_FULL     = 7;
    localparam int unsigned FL_TX_EMPTY    = 6;
    localparam int unsigned FL_TX_AL_FULL  = 5;
    localparam int unsigned FL_TX_AL_EMPTY = 4;
    localparam int unsigned FL_RX_FULL     = 3;
    localparam int unsigned FL_RX_EMPTY    = 2;
    localparam int unsigned FL_RX_AL_FULL  = 1;
    localparam int unsigned FL_RX_AL_EMPTY = 0;

    localparam logic [31:0] DEF_CTRL_ADDR = 32'h0000_0000;
    localparam logic [31:0] DEF_TX_ADDR   = 32'h0000_0004;
    localparam logic [31:0] DEF_RX_ADDR   = 32'h0000_0008;
    localparam logic [31:0] DEF_STAT_ADDR = 32'h0000_000C;

    // Both FIFOs empty: the assumed flags before the first poll
    localparam logic [7:0] STAT_RESET = 8'h44;

endpackage

// File: rtl/apb_stream_master_if.sv
// APB initiator bus plus the sample source/sink handshakes of the stream master.
interface apb_stream_master_if;

    logic        penable;
    logic        pwrite;
    logic [31:0] paddr;
    logic [31:0] pwdata;
    logic [31:0] prdata;

    logic [31:0] tx_data;
    logic        tx_valid;
    logic        tx_ready;

    logic [31:0] rx_data;
    logic        rx_valid;
    logic        rx_ready;

    modport master (
        output penable, pwrite, paddr, pwdata, tx_ready, rx_data, rx_valid,
        input  prdata, tx_data, tx_valid, rx_ready
    );

    modport slave (
        input  penable, pwrite, paddr, pwdata, tx_ready, rx_data, rx_valid,
        output prdata, tx_data, tx_valid, rx_ready
    );

endinterface

// File: rtl/apb_stream_master_xfer.sv
// Two-phase zero-wait-state APB transfer engine: a start pulse launches the
// setup phase on the next edge, the access phase follows one cycle later.
module apb_xfer (
    input  logic        pclk,
    input  logic        preset,
    input  logic        i_start,
    input  logic [31:0] i_addr,
    input  logic        i_write,
    input  logic [31:0] i_wdata,
    input  logic [31:0] i_prdata,
    output logic        o_penable,
    output logic        o_pwrite,
    output logic [31:0] o_paddr,
    output logic [31:0] o_pwdata,
    output logic        o_done,
    output logic [31:0] o_rdata
);

    logic        r_setup;
    logic        r_penable;
    logic        r_pwrite;
    logic [31:0] r_paddr;
    logic [31:0] r_pwdata;

    always_ff @(posedge pclk or negedge preset) begin
        if (!preset) begin
            r_setup   <= 1'b0;
            r_penable <= 1'b0;
            r_pwrite  <= 1'b0;
            r_paddr   <= '0;
            r_pwdata  <= '0;
        end else begin
            r_setup   <= i_start;
            r_penable <= r_setup;
            if (i_start) begin
                r_paddr  <= i_addr;
                r_pwrite <= i_write;
                // Reads leave the last write data on the bus
                if (i_write) begin
                    r_pwdata <= i_wdata;
                end
            end
        end
    end

    assign o_penable = r_penable;
    assign o_pwrite  = r_pwrite;
    assign o_paddr   = r_paddr;
    assign o_pwdata  = r_pwdata;
    assign o_done    = r_penable;
    assign o_rdata   = i_prdata;

endmodule

// File: rtl/apb_stream_master.sv
// Sequencing FSM that configures the I2S transceiver, polls its flags and
// streams samples between the valid/ready ports and its FIFO registers.
module apb_stream_master
    import apb_stream_master_pkg::*;
#(
    parameter logic [31:0] CTRL_ADDR = DEF_CTRL_ADDR,
    parameter logic [31:0] TX_ADDR   = DEF_TX_ADDR,
    parameter logic [31:0] RX_ADDR   = DEF_RX_ADDR,
    parameter logic [31:0] STAT_ADDR = DEF_STAT_ADDR
) (
    input  logic                       pclk,
    input  logic                       preset,
    input  logic                       en,
    input  logic [14:0]                cfg_word,
    apb_stream_master_if.master        bus,
    output logic [7:0]                 stat,
    output logic                       busy
);

    apbm_state_t r_state;
    apbm_state_t w_next;

    logic [7:0]  r_stat;
    logic [31:0] r_rx_data;
    logic        r_rx_valid;

    logic        w_start;
    logic        w_write;
    logic [31:0] w_addr;
    logic [31:0] w_wdata;
    logic        w_tx_take;
    logic        w_done;
    logic [31:0] w_rdata;

    always_ff @(posedge pclk or negedge preset) begin
        if (!preset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        w_tx_take = 1'b0;
        w_start   = 1'b0;
        w_write   = 1'b0;
        w_addr    = STAT_ADDR;
        w_wdata   = '0;

        unique case (r_state)
            IDLE:               if (en) w_next = CFG_S;
            CFG_S:              w_next = CFG_A;
            CFG_A, WR_A, RD_A:  w_next = POLL_S;
            POLL_S:             w_next = POLL_A;
            POLL_A:             w_next = DECIDE;
            DECIDE: begin
                if (!en) begin
                    w_next = IDLE;
                end else if (!r_stat[FL_RX_EMPTY] && !r_rx_valid) begin
                    w_next = RD_S;
                end else if (bus.tx_valid && !r_stat[FL_TX_FULL]) begin
                    w_next    = WR_S;
                    w_tx_take = 1'b1;
                end else begin
                    w_next = POLL_S;
                end
            end
            WR_S:               w_next = WR_A;
            RD_S:               w_next = RD_A;
            default:            w_next = IDLE;
        endcase

        // A transfer is launched on the edge that enters its setup state
        unique case (w_next)
            CFG_S: begin
                w_start = 1'b1;
                w_write = 1'b1;
                w_addr  = CTRL_ADDR;
                w_wdata = {17'b0, cfg_word};
            end
            POLL_S: begin
                w_start = 1'b1;
                w_addr  = STAT_ADDR;
            end
            WR_S: begin
                w_start = 1'b1;
                w_write = 1'b1;
                w_addr  = TX_ADDR;
                w_wdata = bus.tx_data;
            end
            RD_S: begin
                w_start = 1'b1;
                w_addr  = RX_ADDR;
            end
            default: ;
        endcase
    end

    always_ff @(posedge pclk or negedge preset) begin
        if (!preset) begin
            r_stat     <= STAT_RESET;
            r_rx_data  <= '0;
            r_rx_valid <= 1'b0;
        end else begin
            if (r_state == POLL_A && w_done) begin
                r_stat <= w_rdata[7:0];
            end
            if (r_state == RD_A && w_done) begin
                r_rx_data  <= w_rdata;
                r_rx_valid <= 1'b1;
            end else if (r_rx_valid && bus.rx_ready) begin
                r_rx_valid <= 1'b0;
            end
        end
    end

    apb_xfer u_xfer (
        .pclk      (pclk),
        .preset    (preset),
        .i_start   (w_start),
        .i_addr    (w_addr),
        .i_write   (w_write),
        .i_wdata   (w_wdata),
        .i_prdata  (bus.prdata),
        .o_penable (bus.penable),
        .o_pwrite  (bus.pwrite),
        .o_paddr   (bus.paddr),
        .o_pwdata  (bus.pwdata),
        .o_done    (w_done),
        .o_rdata   (w_rdata)
    );

    assign bus.tx_ready = w_tx_take;
    assign bus.rx_data  = r_rx_data;
    assign bus.rx_valid = r_rx_valid;
    assign stat         = r_stat;
    assign busy         = (r_state != IDLE);

endmodule

// File: tb/tb_apb_stream_master.sv
// Directed and randomized bench for apb_stream_master; the bench plays the
// transceiver's APB slave and predicts each bus transaction from the flags.
module tb_apb_stream_master;

    localparam logic [31:0] A_CTRL = 32'h0;
    localparam logic [31:0] A_TX   = 32'h4;
    localparam logic [31:0] A_RX   = 32'h8;
    localparam logic [31:0] A_STAT = 32'hC;

    typedef enum int {K_POLL, K_RD, K_WR, K_IDLE} kind_t;

    logic        pclk = 1'b0;
    logic        preset = 1'b1;
    logic        en = 1'b0;
    logic [14:0] cfg_word = '0;
    logic [7:0]  stat;
    logic        busy;

    logic [7:0]  flags = 8'h44;
    logic [31:0] rx_mem = '0;

    int unsigned n_pass = 0;
    int unsigned n_total = 0;
    int unsigned cyc = 0;
    bit          txr_seen = 1'b0;

    apb_stream_master_if bus();

    apb_stream_master #(
        .CTRL_ADDR (A_CTRL),
        .TX_ADDR   (A_TX),
        .RX_ADDR   (A_RX),
        .STAT_ADDR (A_STAT)
    ) dut (
        .pclk     (pclk),
        .preset   (preset),
        .en       (en),
        .cfg_word (cfg_word),
        .bus      (bus),
        .stat     (stat),
        .busy     (busy)
    );

    always #5 pclk = ~pclk;
    always @(posedge pclk) cyc <= cyc + 1;

    // Transceiver register file as seen by the master
    assign bus.prdata = (bus.paddr == A_STAT) ? {24'h0, flags} :
                        (bus.paddr == A_RX)   ? rx_mem : 32'hDEAD_BEEF;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge pclk);
        #1;
    endtask

    // Next access phase; also verifies the preceding cycle was its setup phase
    task automatic next_access(output logic [31:0] a, output logic w, output logic [31:0] d);
        logic [31:0] pa;
        logic        pw;
        logic        pen;
        bit          found;
        found = 1'b0;
        a = '0; w = 1'b0; d = '0;
        pa = '0; pw = 1'b0; pen = 1'b0;
        for (int i = 0; i < 16; i++) begin
            pa  = bus.paddr;
            pw  = bus.pwrite;
            pen = bus.penable;
            tick();
            if (bus.tx_ready === 1'b1) txr_seen = 1'b1;
            if (bus.penable === 1'b1) begin
                found = 1'b1;
                break;
            end
        end
        check("access_seen", {31'b0, found}, 32'd1);
        if (found) begin
            a = bus.paddr;
            w = bus.pwrite;
            d = bus.pwdata;
            check("setup_penable", {31'b0, pen}, 32'd0);
            check("setup_paddr", pa, a);
            check("setup_pwrite", {31'b0, pw}, {31'b0, w});
        end
    endtask

    function automatic kind_t model_decide(bit en_l, logic [7:0] st, bit rx_pend, bit txv);
        if (!en_l) return K_IDLE;
        if (!st[2] && !rx_pend) return K_RD;
        if (txv && !st[7]) return K_WR;
        return K_POLL;
    endfunction

    initial begin
        logic [31:0] a, d, rxv, rxv2, exp_a;
        logic        w;
        int unsigned c0, c1;
        logic [7:0]  st_m;
        bit          pend_m, rr_prev, read_done, found;
        kind_t       k;

        bus.tx_data  = '0;
        bus.tx_valid = 1'b0;
        bus.rx_ready = 1'b0;
        c0 = 0; c1 = 0; rxv = '0;

        #1 preset = 1'b0;
        #1;
        check("rst_penable", {31'b0, bus.penable}, 32'd0);
        check("rst_pwrite", {31'b0, bus.pwrite}, 32'd0);
        check("rst_paddr", bus.paddr, 32'd0);
        check("rst_pwdata", bus.pwdata, 32'd0);
        check("rst_tx_ready", {31'b0, bus.tx_ready}, 32'd0);
        check("rst_rx_valid", {31'b0, bus.rx_valid}, 32'd0);
        check("rst_rx_data", bus.rx_data, 32'd0);
        check("rst_stat", {24'b0, stat}, 32'h44);
        check("rst_busy", {31'b0, busy}, 32'd0);
        repeat (2) @(posedge pclk);
        #1 preset = 1'b1;
        tick();
        check("idle_busy", {31'b0, busy}, 32'd0);

        // Enable start: control write with 2-cycle setup/access, then status read
        cfg_word = 15'h1A5;
        en = 1'b1;
        tick();
        check("cfg_setup_penable", {31'b0, bus.penable}, 32'd0);
        check("cfg_setup_paddr", bus.paddr, A_CTRL);
        check("cfg_setup_pwrite", {31'b0, bus.pwrite}, 32'd1);
        check("cfg_setup_pwdata", bus.pwdata, 32'h1A5);
        check("cfg_busy", {31'b0, busy}, 32'd1);
        tick();
        check("cfg_acc_penable", {31'b0, bus.penable}, 32'd1);
        check("cfg_acc_paddr", bus.paddr, A_CTRL);
        check("cfg_acc_pwdata", bus.pwdata, 32'h1A5);
        next_access(a, w, d);
        check("cfg_poll_addr", a, A_STAT);
        check("cfg_poll_write", {31'b0, w}, 32'd0);

        // Tx stream of four samples, one accepted every 5 cycles
        bus.tx_data  = 32'hA0;
        bus.tx_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            for (int n = 0; n < 12 && bus.tx_ready !== 1'b1; n++) tick();
            check("tx_ready_pulse", {31'b0, bus.tx_ready}, 32'd1);
            c1 = cyc;
            if (i > 0) check("tx_spacing", c1 - c0, 32'd5);
            c0 = c1;
            tick();
            check("tx_ready_drop", {31'b0, bus.tx_ready}, 32'd0);
            if (i < 3) bus.tx_data = 32'hA0 + i + 1;
            else bus.tx_valid = 1'b0;
            next_access(a, w, d);
            check("tx_addr", a, A_TX);
            check("tx_write", {31'b0, w}, 32'd1);
            check("tx_data", d, 32'hA0 + i);
        end

        // Tx full: three polls with no write, then write after the next decision
        flags = 8'h84;
        bus.tx_data  = $urandom;
        bus.tx_valid = 1'b1;
        txr_seen = 1'b0;
        for (int i = 0; i < 3; i++) begin
            next_access(a, w, d);
            check("full_poll_addr", a, A_STAT);
        end
        check("full_no_tx_ready", {31'b0, txr_seen}, 32'd0);
        tick();
        check("full_stat", {24'b0, stat}, 32'h84);
        flags = 8'h44;
        next_access(a, w, d);
        check("unfull_poll_addr", a, A_STAT);
        c0 = cyc;
        next_access(a, w, d);
        check("unfull_tx_addr", a, A_TX);
        check("unfull_tx_data", d, bus.tx_data);
        check("unfull_latency", cyc - c0, 32'd3);
        bus.tx_valid = 1'b0;

        // Rx priority and sink backpressure
        flags = 8'h00;
        bus.tx_valid = 1'b1;
        bus.tx_data  = $urandom;
        bus.rx_ready = 1'b0;
        rxv    = $urandom;
        rx_mem = rxv;
        next_access(a, w, d);
        check("rxp_poll_addr", a, A_STAT);
        next_access(a, w, d);
        check("rxp_rd_addr", a, A_RX);
        check("rxp_rd_write", {31'b0, w}, 32'd0);
        tick();
        check("rxp_rx_valid", {31'b0, bus.rx_valid}, 32'd1);
        check("rxp_rx_data", bus.rx_data, rxv);
        rx_mem = ~rxv;
        for (int i = 0; i < 3; i++) begin
            next_access(a, w, d);
            check("rxp_poll2_addr", a, A_STAT);
            next_access(a, w, d);
            check("rxp_wr_addr", a, A_TX);
            check("rxp_wr_data", d, bus.tx_data);
            bus.tx_data = $urandom;
        end
        check("rxp_hold_valid", {31'b0, bus.rx_valid}, 32'd1);
        check("rxp_hold_data", bus.rx_data, rxv);
        bus.tx_valid = 1'b0;
        bus.rx_ready = 1'b1;
        tick();
        check("rxp_consumed", {31'b0, bus.rx_valid}, 32'd0);
        bus.rx_ready = 1'b0;

        // Disable while a read is in its setup phase
        rxv2 = $urandom;
        rx_mem = rxv2;
        found = 1'b0;
        for (int n = 0; n < 12; n++) begin
            tick();
            if (bus.paddr == A_RX && bus.penable === 1'b0) begin
                found = 1'b1;
                break;
            end
        end
        check("dis_rd_setup_seen", {31'b0, found}, 32'd1);
        en = 1'b0;
        tick();
        check("dis_rd_access", {31'b0, bus.penable}, 32'd1);
        check("dis_rd_paddr", bus.paddr, A_RX);
        tick();
        check("dis_rx_valid", {31'b0, bus.rx_valid}, 32'd1);
        check("dis_rx_data", bus.rx_data, rxv2);
        for (int n = 0; n < 8 && busy !== 1'b0; n++) tick();
        check("dis_busy", {31'b0, busy}, 32'd0);
        check("dis_penable", {31'b0, bus.penable}, 32'd0);
        check("dis_rx_held", {31'b0, bus.rx_valid}, 32'd1);

        // Randomized streaming against the decision model
        bus.rx_ready = 1'b1;
        tick();
        check("rand_pre_drain", {31'b0, bus.rx_valid}, 32'd0);
        bus.rx_ready = 1'b0;
        cfg_word = 15'($urandom);
        flags = 8'h44;
        en = 1'b1;
        next_access(a, w, d);
        check("rand_cfg_addr", a, A_CTRL);
        check("rand_cfg_data", d, {17'b0, cfg_word});
        next_access(a, w, d);
        check("rand_first_poll", a, A_STAT);
        tick();
        st_m = 8'h44; pend_m = 1'b0; rr_prev = 1'b0; read_done = 1'b0;
        for (int it = 0; it < 30; it++) begin
            pend_m    = (pend_m || read_done) && !rr_prev;
            read_done = 1'b0;
            rr_prev   = 1'($urandom_range(0, 1));
            bus.rx_ready = rr_prev;
            bus.tx_valid = 1'($urandom_range(0, 1));
            bus.tx_data  = $urandom;
            flags  = 8'($urandom);
            rx_mem = $urandom;
            #1;
            k = model_decide(1'b1, st_m, pend_m, bus.tx_valid);
            check("rand_stat", {24'b0, stat}, {24'b0, st_m});
            check("rand_rx_valid", {31'b0, bus.rx_valid}, {31'b0, pend_m});
            check("rand_tx_ready", {31'b0, bus.tx_ready}, {31'b0, (k == K_WR)});
            if (pend_m) check("rand_rx_data", bus.rx_data, rxv);
            if (k != K_POLL) begin
                next_access(a, w, d);
                exp_a = (k == K_RD) ? A_RX : A_TX;
                check("rand_xfer_addr", a, exp_a);
                check("rand_xfer_write", {31'b0, w}, {31'b0, (k == K_WR)});
                if (k == K_WR) check("rand_wr_data", d, bus.tx_data);
                if (k == K_RD) begin
                    rxv = rx_mem;
                    read_done = 1'b1;
                end
            end
            next_access(a, w, d);
            check("rand_poll_addr", a, A_STAT);
            st_m = flags;
            tick();
        end

        // Reset asserted in the middle of a write access phase
        flags = 8'h44;
        bus.tx_valid = 1'b1;
        bus.tx_data  = $urandom;
        bus.rx_ready = 1'b1;
        found = 1'b0;
        for (int n = 0; n < 20; n++) begin
            tick();
            if (bus.penable === 1'b1 && bus.paddr == A_TX) begin
                found = 1'b1;
                break;
            end
        end
        check("mid_wr_access_seen", {31'b0, found}, 32'd1);
        #1 preset = 1'b0;
        #1;
        check("mid_rst_penable", {31'b0, bus.penable}, 32'd0);
        check("mid_rst_busy", {31'b0, busy}, 32'd0);
        check("mid_rst_stat", {24'b0, stat}, 32'h44);
        check("mid_rst_paddr", bus.paddr, 32'd0);
        check("mid_rst_pwdata", bus.pwdata, 32'd0);
        en = 1'b0;
        @(negedge pclk);
        preset = 1'b1;
        tick();
        check("post_rst_busy", {31'b0, busy}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
